// File: rtl/demux_pkg.sv
// -----------------------------------------------------------------------------
// demux_pkg
// Shared constants for the registered 1-to-4 demultiplexer.
//   SEL_CH0..SEL_CH3    : channel-select codes
//   DEMUX_CNT_W         : width of the optional per-channel transfer counters
//   DEMUX_DEFAULT_WIDTH : default data width
//   sel_onehot()        : select code -> one-hot channel mask
// Optional feature macro used by the design: DEMUX_STATS_EN
// -----------------------------------------------------------------------------
package demux_pkg;

    localparam logic [1:0] SEL_CH0 = 2'b00;
    localparam logic [1:0] SEL_CH1 = 2'b01;
    localparam logic [1:0] SEL_CH2 = 2'b10;
    localparam logic [1:0] SEL_CH3 = 2'b11;

    localparam int DEMUX_CNT_W         = 8;
    localparam int DEMUX_DEFAULT_WIDTH = 3;

    function automatic logic [3:0] sel_onehot(input logic [1:0] s);
        logic [3:0] m;
        m = 4'b0000;
        case (s)
            SEL_CH0: m = 4'b0001;
            SEL_CH1: m = 4'b0010;
            SEL_CH2: m = 4'b0100;
            SEL_CH3: m = 4'b1000;
            default: m = 4'b0000;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/demux_slot.sv
// -----------------------------------------------------------------------------
// demux_slot
// One-deep output holding slot with valid/ready drain and optional counter.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   load        : write load_data into the slot this edge (sets valid)
//   load_data   : value to store
//   ready       : consumer takes the slot value when valid is high
//   data        : slot contents (holds last value after drain)
//   valid       : slot holds an undelivered value
//   slot_ready  : slot can accept a load this cycle (!valid || ready)
//   count       : delivered-transfer counter (only with DEMUX_STATS_EN)
// Handshake: a transfer happens on an edge where valid && ready are both high;
// valid never drops and data never changes before that transfer completes.
// -----------------------------------------------------------------------------
module demux_slot
    import demux_pkg::*;
#(
    parameter int WIDTH = DEMUX_DEFAULT_WIDTH
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   load,
    input  logic [WIDTH-1:0]       load_data,
    input  logic                   ready,
    output logic [WIDTH-1:0]       data,
    output logic                   valid,
    output logic                   slot_ready
`ifdef DEMUX_STATS_EN
    ,
    output logic [DEMUX_CNT_W-1:0] count
`endif
);

    logic [WIDTH-1:0] r_data;
    logic             r_valid;
    logic             w_drain;

    assign w_drain    = r_valid && ready;
    assign slot_ready = !r_valid || ready;
    assign data       = r_data;
    assign valid      = r_valid;

    // A load wins over a drain: same-cycle drain and refill keeps valid high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_data  <= '0;
            r_valid <= 1'b0;
        end else if (load) begin
            r_data  <= load_data;
            r_valid <= 1'b1;
        end else if (w_drain) begin
            r_valid <= 1'b0;
        end
    end

`ifdef DEMUX_STATS_EN
    logic [DEMUX_CNT_W-1:0] r_count;

    // Free-running wrap at 2**DEMUX_CNT_W.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (w_drain) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign count = r_count;
`endif

endmodule

// File: rtl/demux1x4_3bit_reg.sv
// -----------------------------------------------------------------------------
// demux1x4_3bit_reg
// Registered 1-to-4 demultiplexer. in_data is steered by sel into one of four
// one-deep holding slots, each drained independently by its consumer.
// Ports:
//   clk, rst_n            : clock, asynchronous active-low reset
//   in_data, sel          : value and target channel
//   in_valid / in_ready   : source handshake (in_ready reflects slot sel)
//   outN_data/outN_valid  : slot N contents and occupancy
//   outN_ready            : consumer N takes the slot value
//   outN_count            : delivered transfers on N (only with DEMUX_STATS_EN)
// Handshake: a transfer on any channel happens on an edge where its valid and
// ready are both high; once valid rises it stays high with stable payload
// until that transfer.
// Optional feature macro: DEMUX_STATS_EN (adds the outN_count ports).
// -----------------------------------------------------------------------------
module demux1x4_3bit_reg
    import demux_pkg::*;
#(
    parameter int WIDTH = DEMUX_DEFAULT_WIDTH
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [WIDTH-1:0]       in_data,
    input  logic [1:0]             sel,
    input  logic                   in_valid,
    output logic                   in_ready,
    output logic [WIDTH-1:0]       out0_data,
    output logic [WIDTH-1:0]       out1_data,
    output logic [WIDTH-1:0]       out2_data,
    output logic [WIDTH-1:0]       out3_data,
    output logic                   out0_valid,
    output logic                   out1_valid,
    output logic                   out2_valid,
    output logic                   out3_valid,
    input  logic                   out0_ready,
    input  logic                   out1_ready,
    input  logic                   out2_ready,
    input  logic                   out3_ready
`ifdef DEMUX_STATS_EN
    ,
    output logic [DEMUX_CNT_W-1:0] out0_count,
    output logic [DEMUX_CNT_W-1:0] out1_count,
    output logic [DEMUX_CNT_W-1:0] out2_count,
    output logic [DEMUX_CNT_W-1:0] out3_count
`endif
);

    logic [3:0]       w_sel_dec;
    logic [3:0]       w_load;
    logic [3:0]       w_ready;
    logic [3:0]       w_slot_ready;
    logic [3:0]       w_valid;
    logic [WIDTH-1:0] w_data [4];
    logic             w_in_ready;
    logic             w_accept;
`ifdef DEMUX_STATS_EN
    logic [DEMUX_CNT_W-1:0] w_count [4];
`endif

    assign w_ready   = {out3_ready, out2_ready, out1_ready, out0_ready};
    assign w_sel_dec = sel_onehot(sel);

    // in_ready depends only on the addressed slot, so a stalled channel never
    // blocks traffic to the others.
    always_comb begin
        w_in_ready = 1'b0;
        case (sel)
            SEL_CH0: w_in_ready = w_slot_ready[0];
            SEL_CH1: w_in_ready = w_slot_ready[1];
            SEL_CH2: w_in_ready = w_slot_ready[2];
            SEL_CH3: w_in_ready = w_slot_ready[3];
            default: w_in_ready = 1'b0;
        endcase
    end

    assign w_accept = in_valid && w_in_ready;
    assign w_load   = w_sel_dec & {4{w_accept}};
    assign in_ready = w_in_ready;

    for (genvar g = 0; g < 4; g++) begin : g_slot
        demux_slot #(
            .WIDTH(WIDTH)
        ) u_slot (
            .clk        (clk),
            .rst_n      (rst_n),
            .load       (w_load[g]),
            .load_data  (in_data),
            .ready      (w_ready[g]),
            .data       (w_data[g]),
            .valid      (w_valid[g]),
            .slot_ready (w_slot_ready[g])
`ifdef DEMUX_STATS_EN
            ,
            .count      (w_count[g])
`endif
        );
    end

    assign out0_data  = w_data[0];
    assign out1_data  = w_data[1];
    assign out2_data  = w_data[2];
    assign out3_data  = w_data[3];
    assign out0_valid = w_valid[0];
    assign out1_valid = w_valid[1];
    assign out2_valid = w_valid[2];
    assign out3_valid = w_valid[3];

`ifdef DEMUX_STATS_EN
    assign out0_count = w_count[0];
    assign out1_count = w_count[1];
    assign out2_count = w_count[2];
    assign out3_count = w_count[3];
`endif

endmodule

// File: tb/tb_demux1x4_3bit_reg.sv
// -----------------------------------------------------------------------------
// tb_demux1x4_3bit_reg
// Self-checking bench for demux1x4_3bit_reg: directed scenarios followed by
// randomized traffic, compared each cycle against a slot-level reference
// model. Counter checks are active when DEMUX_STATS_EN is defined.
// -----------------------------------------------------------------------------
module tb_demux1x4_3bit_reg;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic [2:0] in_data;
  logic [1:0] sel;
  logic       in_valid;
  logic [3:0] o_rdy;
  wire        in_ready;
  wire  [2:0] w_od [4];
  wire  [3:0] w_ov;
`ifdef DEMUX_STATS_EN
  wire  [7:0] w_cnt [4];
`endif

  demux1x4_3bit_reg #(.WIDTH(3)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_data    (in_data),
    .sel        (sel),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .out0_data  (w_od[0]),
    .out1_data  (w_od[1]),
    .out2_data  (w_od[2]),
    .out3_data  (w_od[3]),
    .out0_valid (w_ov[0]),
    .out1_valid (w_ov[1]),
    .out2_valid (w_ov[2]),
    .out3_valid (w_ov[3]),
    .out0_ready (o_rdy[0]),
    .out1_ready (o_rdy[1]),
    .out2_ready (o_rdy[2]),
    .out3_ready (o_rdy[3])
`ifdef DEMUX_STATS_EN
    ,
    .out0_count (w_cnt[0]),
    .out1_count (w_cnt[1]),
    .out2_count (w_cnt[2]),
    .out3_count (w_cnt[3])
`endif
  );

  // reference model: contents, occupancy and delivered-transfer totals
  int m_data  [4];
  bit m_valid [4];
  int m_total [4];
  bit last_acc;

  // scoreboard: values accepted for channel 2 awaiting delivery
  logic [2:0] exp_q[$];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 4; i++) begin
      m_data[i]  = 0;
      m_valid[i] = 1'b0;
      m_total[i] = 0;
    end
    last_acc = 1'b0;
  endtask

  // One clock: compare at negedge, advance model on the posedge, return #1 later.
  task automatic step();
    bit acc;
    bit drain [4];
    bit exp_rdy;
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("data%0d", i), int'(w_od[i]), m_data[i]);
      check($sformatf("valid%0d", i), int'(w_ov[i]), int'(m_valid[i]));
`ifdef DEMUX_STATS_EN
      check($sformatf("count%0d", i), int'(w_cnt[i]), m_total[i] % 256);
`endif
    end
    exp_rdy = !m_valid[sel] || o_rdy[sel];
    check("in_ready", int'(in_ready), int'(exp_rdy));
    acc = in_valid && exp_rdy;
    for (int i = 0; i < 4; i++) drain[i] = m_valid[i] && o_rdy[i];
    @(posedge clk);
    for (int i = 0; i < 4; i++) begin
      if (drain[i]) m_total[i]++;
      if (acc && int'(sel) == i) begin
        m_data[i]  = int'(in_data);
        m_valid[i] = 1'b1;
      end else if (drain[i]) begin
        m_valid[i] = 1'b0;
      end
    end
    if (drain[2] && exp_q.size() > 0) begin
      logic [2:0] e;
      e = exp_q.pop_front();
      check("sb_ch2", m_data[2] == -1 ? 0 : int'(e), int'(e));
    end
    if (acc && sel == 2'd2) exp_q.push_back(in_data);
    last_acc = acc;
    #1;
  endtask

  // Asynchronous reset asserted between edges; checks outputs immediately.
  task automatic do_reset();
    #2;
    rst_n = 1'b0;
    #1;
    model_clear();
    exp_q.delete();
    for (int i = 0; i < 4; i++) begin
      check($sformatf("rst_valid%0d", i), int'(w_ov[i]), 0);
      check($sformatf("rst_data%0d", i), int'(w_od[i]), 0);
`ifdef DEMUX_STATS_EN
      check($sformatf("rst_count%0d", i), int'(w_cnt[i]), 0);
`endif
    end
    for (int s = 0; s < 4; s++) begin
      sel = 2'(s);
      #1;
      check($sformatf("rst_in_ready_sel%0d", s), int'(in_ready), 1);
    end
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit v, input logic [1:0] s, input logic [2:0] d);
    in_valid = v;
    sel      = s;
    in_data  = d;
  endtask

  int accepted;

  initial begin
    rst_n = 1'b1;
    o_rdy = 4'b0000;
    drive(1'b0, 2'd0, 3'd0);
    model_clear();
    #1;
    do_reset();

    // stuff some state, then reset mid-stream
    o_rdy = 4'b0000;
    drive(1'b1, 2'd1, 3'd6); step();
    drive(1'b1, 2'd3, 3'd4); step();
    drive(1'b0, 2'd0, 3'd0);
    do_reset();

    // reset recovery: 3'b101 to channel 2
    drive(1'b1, 2'd2, 3'b101); step();
    drive(1'b0, 2'd0, 3'd0);
    check("rec_valid2", int'(w_ov[2]), 1);
    check("rec_data2", int'(w_od[2]), 5);
    o_rdy = 4'b0100; step();
    o_rdy = 4'b0000;

    // backpressure on channel 1
    drive(1'b1, 2'd1, 3'b011); step();
    drive(1'b1, 2'd1, 3'b110);
    #1;
    check("bp_in_ready", int'(in_ready), 0);
    step(); step();
    check("bp_hold", int'(w_od[1]), 3);
    o_rdy[1] = 1'b1;
    #1;
    check("bp_release_rdy", int'(in_ready), 1);
    step();
    check("bp_refill", int'(w_od[1]), 6);
    check("bp_refill_v", int'(w_ov[1]), 1);
    drive(1'b0, 2'd0, 3'd0);
    step();
    o_rdy = 4'b0000;

    // independence: slot 0 stalled, channel 3 still accepts
    drive(1'b1, 2'd0, 3'b001); step();
    drive(1'b1, 2'd3, 3'b111);
    #1;
    check("ind_in_ready", int'(in_ready), 1);
    step();
    drive(1'b0, 2'd0, 3'd0);
    check("ind_data3", int'(w_od[3]), 7);
    check("ind_data0", int'(w_od[0]), 1);
    check("ind_valid0", int'(w_ov[0]), 1);

    // simultaneous drain and refill on channel 0
    o_rdy[0] = 1'b1;
    drive(1'b1, 2'd0, 3'b010); step();
    drive(1'b0, 2'd0, 3'd0);
    check("sim_valid0", int'(w_ov[0]), 1);
    check("sim_data0", int'(w_od[0]), 2);
    o_rdy = 4'b1111; step();
    o_rdy = 4'b0000;

    // streaming 0..7 into channel 2 with consumer always ready
    o_rdy[2] = 1'b1;
    accepted = 0;
    for (int v = 0; v < 8; v++) begin
      drive(1'b1, 2'd2, 3'(v));
      #1;
      if (in_ready) accepted++;
      step();
      check($sformatf("stream_data_%0d", v), int'(w_od[2]), v);
    end
    drive(1'b0, 2'd0, 3'd0);
    check("stream_accepted", accepted, 8);
    step();
    check("stream_empty", int'(w_ov[2]), 0);

    // randomized traffic honoring the source hold rule
    for (int n = 0; n < 1500; n++) begin
      o_rdy = 4'($urandom_range(0, 15));
      if (!(in_valid && !last_acc))
        drive(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)));
      step();
    end
    drive(1'b0, 2'd0, 3'd0);
    o_rdy = 4'b1111;
    step(); step();

`ifdef DEMUX_STATS_EN
    // counter wrap: 257 transfers on channel 3
    do_reset();
    o_rdy = 4'b1000;
    drive(1'b1, 2'd3, 3'd5);
    for (int n = 0; n < 257; n++) step();
    drive(1'b0, 2'd0, 3'd0);
    step(); step();
    check("wrap_count3", int'(w_cnt[3]), 1);
    check("wrap_count0", int'(w_cnt[0]), 0);
    check("wrap_count1", int'(w_cnt[1]), 0);
    check("wrap_count2", int'(w_cnt[2]), 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // global watchdog
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
